// File: rtl/seq_if.sv
// Handshake and config bundle between the AXI config block,
// the sequence scheduler and the RAM-to-register loader.
interface seq_if #(
  parameter int AW = 10,
  parameter int SW = 16
);
  logic          start;
  logic          stop;
  logic [AW-1:0] cfg_base;
  logic [SW-1:0] cfg_steps;
  logic [31:0]   cfg_period;
  logic          cfg_loop;
  logic [AW-1:0] read_addr;
  logic          read_trigger;
  logic          seq_load;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          done;
  logic          aborted;

  modport master (
    output start, stop, cfg_base, cfg_steps,
    output cfg_period, cfg_loop,
    input  read_addr, read_trigger, seq_load,
    input  step_idx, busy, done, aborted
  );

  modport slave (
    input  start, stop, cfg_base, cfg_steps,
    input  cfg_period, cfg_loop,
    output read_addr, read_trigger, seq_load,
    output step_idx, busy, done, aborted
  );
endinterface

// File: rtl/seq_scheduler.sv
// Steps the sequence engine through per-step register sets in RAM:
// trigger loader, wait load latency, apply, dwell, advance.
module seq_scheduler #(
  parameter int REG_NUM  = 10,
  parameter int BUF_NUM  = 80,
  parameter int LOAD_LAT = REG_NUM + 3,
  parameter int SW       = 16
) (
  input logic clk,
  input logic rst,
  seq_if.slave bus
);
  localparam int AW = $clog2(REG_NUM * BUF_NUM);

  typedef enum logic [2:0] {
    IDLE, TRIG, LOAD, DWELL, DONE
  } state_t;

  state_t        state, state_n;
  logic [31:0]   cnt, cnt_n;
  logic [SW-1:0] idx, idx_n;
  logic [AW-1:0] addr, addr_n;
  logic [AW-1:0] base_q;
  logic [SW-1:0] steps_q;
  logic [31:0]   per_m1_q;
  logic          loop_q;
  logic          latch;
  logic          more;
  logic          act;
  logic          kill;

  assign act  = (state != IDLE);
  assign kill = rst | bus.stop;
  assign more = ((idx + SW'(1)) < steps_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      addr     <= '0;
      base_q   <= '0;
      steps_q  <= '0;
      per_m1_q <= '0;
      loop_q   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      addr  <= addr_n;
      if (latch) begin
        base_q   <= bus.cfg_base;
        steps_q  <= bus.cfg_steps;
        per_m1_q <= (bus.cfg_period == 32'd0) ?
                    32'd0 : bus.cfg_period - 32'd1;
        loop_q   <= bus.cfg_loop;
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    addr_n  = addr;
    latch   = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          bus.start && !bus.stop &&
          (bus.cfg_steps != '0): begin
            latch   = 1'b1;
            state_n = TRIG;
            idx_n   = '0;
            addr_n  = bus.cfg_base;
          end
          bus.start && !bus.stop &&
          (bus.cfg_steps == '0): begin
            latch   = 1'b1;
            state_n = DONE;
          end
          default: ;
        endcase
      end
      TRIG: begin
        state_n = LOAD;
        cnt_n   = 32'(LOAD_LAT - 1);
      end
      LOAD: begin
        if (cnt == 32'd0) begin
          state_n = DWELL;
          cnt_n   = per_m1_q;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      DWELL: begin
        if (cnt == 32'd0) begin
          unique case (1'b1)
            more: begin
              state_n = TRIG;
              idx_n   = idx + SW'(1);
              addr_n  = addr + AW'(REG_NUM);
            end
            !more && loop_q: begin
              state_n = TRIG;
              idx_n   = '0;
              addr_n  = base_q;
            end
            default: state_n = DONE;
          endcase
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // Abort overrides any step decision; the loader finishes by itself.
    if (bus.stop && act) begin
      state_n = IDLE;
      idx_n   = '0;
      addr_n  = '0;
    end
  end

  assign bus.read_addr    = addr;
  assign bus.step_idx     = idx;
  assign bus.busy         = act;
  assign bus.read_trigger = (state == TRIG) && !kill;
  assign bus.seq_load     = (state == DWELL) &&
                            (cnt == per_m1_q) && !kill;
  assign bus.done         = (state == DONE) && !kill;
  assign bus.aborted      = bus.stop && act && !rst;
endmodule
